// File: rtl/prs_pkg.sv
// rtl/prs_pkg.sv - shared types and constants for the pulse-counter readout sequencer
// Contents: sequencer state encoding, command-word bit positions, frame-counter and timer widths.
package prs_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SNAPSHOT = 3'd1;
    localparam logic [2:0] ST_OFFER    = 3'd2;
    localparam logic [2:0] ST_XFER     = 3'd3;
    localparam logic [2:0] ST_APPLY    = 3'd4;
    localparam logic [2:0] ST_RST_HOLD = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_SNAPSHOT = ST_SNAPSHOT,
        S_OFFER    = ST_OFFER,
        S_XFER     = ST_XFER,
        S_APPLY    = ST_APPLY,
        S_RST_HOLD = ST_RST_HOLD
    } prs_state_e;

    localparam int FRAME_CNT_W = 8;
    localparam int TIMER_W     = 16;

    // Command word layout for N channels: [N+1] reset-after-read, [N] enable-update, [N-1:0] mask.
    function automatic int cmd_en_bit(input int n);
        return n;
    endfunction

    function automatic int cmd_rst_bit(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/prs_hold_timer.sv
// rtl/prs_hold_timer.sv - loadable down-counter with done flag, shared by OFFER timeout and reset hold
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          load i_load_val into the counter this cycle
//   i_load_val      value loaded; done asserts that many cycles after the load edge
//   o_done          counter is at zero
module prs_hold_timer
    import prs_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_done = (count_q == '0);

endmodule

// File: rtl/prs_frame_ctrl.sv
// rtl/prs_frame_ctrl.sv - readout sequencer between the pulse-counter bank and the SPI slave
// Ports:
//   i_clk, i_rst_n   system clock, asynchronous active-low reset
//   i_cnt_data       live counter values, channel k at [W*k+W-1:W*k]
//   i_tx_req         SPI slave asks for TX data (honoured in IDLE only)
//   i_spi_busy       SPI frame in progress
//   o_tx_buff        registered snapshot offered to the SPI slave
//   o_tx_valid       snapshot valid (OFFER state decode)
//   i_rx_buff        received command word {reset-after-read, enable-update, mask}
//   i_rx_valid       single-cycle strobe for i_rx_buff
//   o_cnt_enable     per-channel counter enable
//   o_cnt_reset      clear request to the counter bank
//   o_frame_cnt      completed-frame count, wraps
//   o_timeout        sticky OFFER-timeout flag
//   i_err_clr        clears o_timeout (a simultaneous timeout wins)
module prs_frame_ctrl
    import prs_pkg::*;
#(
    parameter int NUMBER_OF_COUNTERS = 16,
    parameter int COUNTERS_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int RST_HOLD_CYCLES    = 4
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] i_cnt_data,
    input  logic                                     i_tx_req,
    input  logic                                     i_spi_busy,
    output logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] o_tx_buff,
    output logic                                     o_tx_valid,
    input  logic [NUMBER_OF_COUNTERS+1:0]            i_rx_buff,
    input  logic                                     i_rx_valid,
    output logic [NUMBER_OF_COUNTERS-1:0]            o_cnt_enable,
    output logic                                     o_cnt_reset,
    output logic [FRAME_CNT_W-1:0]                   o_frame_cnt,
    output logic                                     o_timeout,
    input  logic                                     i_err_clr
);

    localparam int N       = NUMBER_OF_COUNTERS;
    localparam int W       = COUNTERS_WIDTH;
    localparam int EN_BIT  = cmd_en_bit(N);
    localparam int RST_BIT = cmd_rst_bit(N);

    // Loading T-1 makes done coincide with the T-th OFFER cycle; likewise for the hold.
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD    = TIMER_W'(RST_HOLD_CYCLES - 1);

    prs_state_e             state_q,      state_d;
    logic [N*W-1:0]         shadow_q,     shadow_d;
    logic [N+1:0]           cmd_q,        cmd_d;
    logic                   captured_q,   captured_d;
    logic [N-1:0]           cnt_enable_q, cnt_enable_d;
    logic                   cnt_reset_q,  cnt_reset_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q,  frame_cnt_d;
    logic                   timeout_q,    timeout_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_done;

    prs_hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_load_val),
        .o_done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cmd_d        = cmd_q;
        captured_d   = captured_q;
        cnt_enable_d = cnt_enable_q;
        frame_cnt_d  = frame_cnt_q;
        timeout_d    = timeout_q & ~i_err_clr;
        tmr_load     = 1'b0;
        tmr_load_val = TIMEOUT_LOAD;

        case (state_q)
            S_IDLE: begin
                if (i_tx_req) begin
                    state_d = S_SNAPSHOT;
                end
            end
            S_SNAPSHOT: begin
                shadow_d     = i_cnt_data;
                captured_d   = 1'b0;
                tmr_load     = 1'b1;
                tmr_load_val = TIMEOUT_LOAD;
                state_d      = S_OFFER;
            end
            S_OFFER: begin
                // A busy seen in the last timer cycle still starts the transfer.
                if (i_spi_busy) begin
                    state_d = S_XFER;
                end else if (tmr_done) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_XFER: begin
                if (i_rx_valid) begin
                    cmd_d      = i_rx_buff;
                    captured_d = 1'b1;
                end
                if (!i_spi_busy) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    state_d     = (captured_q || i_rx_valid) ? S_APPLY : S_IDLE;
                end
            end
            S_APPLY: begin
                if (cmd_q[EN_BIT]) begin
                    cnt_enable_d = cmd_q[N-1:0];
                end
                tmr_load     = 1'b1;
                tmr_load_val = HOLD_LOAD;
                state_d      = cmd_q[RST_BIT] ? S_RST_HOLD : S_IDLE;
            end
            S_RST_HOLD: begin
                if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so the clear request is high exactly while in RST_HOLD.
        cnt_reset_d = (state_d == S_RST_HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            cmd_q        <= '0;
            captured_q   <= 1'b0;
            cnt_enable_q <= '0;
            cnt_reset_q  <= 1'b0;
            frame_cnt_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cmd_q        <= cmd_d;
            captured_q   <= captured_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_reset_q  <= cnt_reset_d;
            frame_cnt_q  <= frame_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_tx_buff    = shadow_q;
    assign o_tx_valid   = (state_q == S_OFFER);
    assign o_cnt_enable = cnt_enable_q;
    assign o_cnt_reset  = cnt_reset_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_timeout    = timeout_q;

endmodule
